// File: rtl/rrat_commit.sv
// rrat_commit: retirement RAT; commits retiring arch->phys mappings, frees superseded
// physical registers and raises a one-cycle nuke after a mispredicted branch retires.
//   clock, reset (async active-low)
//   retire_valid/arch_reg/phys_reg/mispredict : per-slot retire bundle, slot 0 oldest
//   rrat_entries          : committed arch->phys map (registered)
//   rrat_free_list        : 1 = phys register not referenced by the committed map (registered)
//   free_vector_from_rrat : phys registers released by last cycle's retirements (registered)
//   nuke                  : flush pulse, the cycle after a mispredict retires
//   retired_count         : 64-bit processed-slot counter, present only with RRAT_RETIRE_COUNT_EN
`ifndef N
`define N 3
`endif
`ifndef RAT_SIZE
`define RAT_SIZE 32
`endif
`ifndef PRF_NUM_ENTRIES
`define PRF_NUM_ENTRIES 64
`endif
`ifndef PRF_NUM_INDEX_BITS
`define PRF_NUM_INDEX_BITS 6
`endif
`ifndef REG_INDEX_BITS
`define REG_INDEX_BITS 5
`endif

module rrat_commit (
    input  logic                                                 clock,
    input  logic                                                 reset,
    input  logic [`N-1:0]                                        retire_valid,
    input  logic [`N-1:0][`REG_INDEX_BITS-1:0]                   retire_arch_reg,
    input  logic [`N-1:0][`PRF_NUM_INDEX_BITS-1:0]               retire_phys_reg,
    input  logic [`N-1:0]                                        retire_mispredict,
    output logic [`RAT_SIZE-1:0][`PRF_NUM_INDEX_BITS-1:0]        rrat_entries,
    output logic [`PRF_NUM_ENTRIES-1:0]                          rrat_free_list,
    output logic [`PRF_NUM_ENTRIES-1:0]                          free_vector_from_rrat,
`ifdef RRAT_RETIRE_COUNT_EN
    output logic [63:0]                                          retired_count,
`endif
    output logic                                                 nuke
);
    logic [`RAT_SIZE-1:0][`PRF_NUM_INDEX_BITS-1:0] ent_n;
    logic [`PRF_NUM_ENTRIES-1:0]                   fl_n, fv_n;
    logic [`N-1:0]                                 take;
    logic                                          stop;

    // Slots are walked oldest first so a younger write to the same arch register
    // sees (and frees) the older slot's phys as its previous mapping.
    always_comb begin
        ent_n = rrat_entries;
        fv_n  = '0;
        take  = '0;
        stop  = 1'b0;
        for (int k = 0; k < `N; k++) begin
            take[k] = retire_valid[k] & ~stop & ~nuke;
            if (take[k]) begin
                if (retire_arch_reg[k] != '0) begin
                    fv_n[ent_n[retire_arch_reg[k]]] = 1'b1;
                    ent_n[retire_arch_reg[k]]       = retire_phys_reg[k];
                end
                if (retire_mispredict[k])
                    stop = 1'b1;
            end
        end
        // Free list derived from the next map keeps it exactly the complement of the live set.
        for (int p = 0; p < `PRF_NUM_ENTRIES; p++) begin
            fl_n[p] = 1'b1;
            for (int i = 0; i < `RAT_SIZE; i++)
                if (ent_n[i] == `PRF_NUM_INDEX_BITS'(p))
                    fl_n[p] = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < `RAT_SIZE; i++)
                rrat_entries[i] <= `PRF_NUM_INDEX_BITS'(i);
            for (int p = 0; p < `PRF_NUM_ENTRIES; p++)
                rrat_free_list[p] <= (p >= `RAT_SIZE);
            free_vector_from_rrat <= '0;
            nuke                  <= 1'b0;
        end else begin
            rrat_entries          <= ent_n;
            rrat_free_list        <= fl_n;
            free_vector_from_rrat <= fv_n;
            nuke                  <= stop;
        end
    end

`ifdef RRAT_RETIRE_COUNT_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            retired_count <= '0;
        else
            retired_count <= retired_count + 64'($countones(take));
    end
`endif
endmodule

// File: tb/tb_rrat_commit.sv
// tb_rrat_commit: directed and randomized checks of rrat_commit against a behavioural model
`ifndef N
`define N 3
`endif
`ifndef RAT_SIZE
`define RAT_SIZE 32
`endif
`ifndef PRF_NUM_ENTRIES
`define PRF_NUM_ENTRIES 64
`endif
`ifndef PRF_NUM_INDEX_BITS
`define PRF_NUM_INDEX_BITS 6
`endif
`ifndef REG_INDEX_BITS
`define REG_INDEX_BITS 5
`endif

module tb_rrat_commit;
    localparam int NS = `N;
    localparam int RS = `RAT_SIZE;
    localparam int PN = `PRF_NUM_ENTRIES;
    localparam int PB = `PRF_NUM_INDEX_BITS;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic [NS-1:0]                      retire_valid = '0;
    logic [NS-1:0][`REG_INDEX_BITS-1:0] retire_arch_reg = '0;
    logic [NS-1:0][PB-1:0]              retire_phys_reg = '0;
    logic [NS-1:0]                      retire_mispredict = '0;
    logic [RS-1:0][PB-1:0]              rrat_entries;
    logic [PN-1:0]                      rrat_free_list, free_vector_from_rrat;
    logic                               nuke;
`ifdef RRAT_RETIRE_COUNT_EN
    logic [63:0]                        retired_count;
`endif

    rrat_commit dut (
        .clock(clock), .reset(reset),
        .retire_valid(retire_valid), .retire_arch_reg(retire_arch_reg),
        .retire_phys_reg(retire_phys_reg), .retire_mispredict(retire_mispredict),
        .rrat_entries(rrat_entries), .rrat_free_list(rrat_free_list),
        .free_vector_from_rrat(free_vector_from_rrat),
`ifdef RRAT_RETIRE_COUNT_EN
        .retired_count(retired_count),
`endif
        .nuke(nuke)
    );

    always #5 clock = ~clock;

    int tests = 0, fails = 0;
    int m_map[RS];
    logic [PN-1:0] m_fv;
    bit m_nuke;
    longint unsigned m_cnt;
    bit chk_en = 1'b0;

    function automatic void chk(string nm, logic [255:0] got, logic [255:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endfunction

    task automatic model_reset();
        for (int i = 0; i < RS; i++) m_map[i] = i;
        m_fv = '0; m_nuke = 0; m_cnt = 0;
    endtask

    function automatic logic [PN-1:0] model_free();
        logic [PN-1:0] f = '1;
        for (int i = 0; i < RS; i++) f[m_map[i]] = 1'b0;
        return f;
    endfunction

    function automatic logic [RS*PB-1:0] model_flat();
        logic [RS-1:0][PB-1:0] e;
        for (int i = 0; i < RS; i++) e[i] = PB'(m_map[i]);
        return e;
    endfunction

    // Advance one clock: evaluate retirements on the model from the pre-edge state,
    // then commit it at the edge alongside the DUT.
    task automatic step();
        int nm[RS];
        logic [PN-1:0] nfv = '0;
        bit nn = 0, done = 0;
        int c = 0, a;
        nm = m_map;
        if (!m_nuke)
            for (int k = 0; k < NS; k++)
                if (retire_valid[k] && !done) begin
                    c++;
                    a = int'(retire_arch_reg[k]);
                    if (a != 0) begin
                        nfv[nm[a]] = 1'b1;
                        nm[a] = int'(retire_phys_reg[k]);
                    end
                    if (retire_mispredict[k]) begin done = 1; nn = 1; end
                end
        @(posedge clock);
        m_map = nm; m_fv = nfv; m_nuke = nn; m_cnt += longint'(c);
        #1;
    endtask

    task automatic clear_in();
        retire_valid = '0; retire_arch_reg = '0; retire_phys_reg = '0; retire_mispredict = '0;
    endtask

    task automatic slot(int k, int a, int p, bit mp);
        retire_valid[k] = 1'b1;
        retire_arch_reg[k] = `REG_INDEX_BITS'(a);
        retire_phys_reg[k] = PB'(p);
        retire_mispredict[k] = mp;
    endtask

    always @(negedge clock) begin
        if (chk_en && reset) begin
            chk("entries", 256'(rrat_entries), 256'(model_flat()));
            chk("free_list", 256'(rrat_free_list), 256'(model_free()));
            chk("free_vector", 256'(free_vector_from_rrat), 256'(m_fv));
            chk("nuke", 256'(nuke), 256'(m_nuke));
`ifdef RRAT_RETIRE_COUNT_EN
            chk("retired_count", 256'(retired_count), 256'(m_cnt));
`endif
        end
    end

    initial begin
        logic [PN-1:0] pool;
        logic [PN-1:0] rst_fl;
        int p;
        model_reset();
        #12;
        for (int i = 0; i < PN; i++) rst_fl[i] = (i >= RS);
        chk("rst_entries5", 256'(rrat_entries[5]), 256'(5));
        chk("rst_free_list", 256'(rrat_free_list), 256'(rst_fl));
        chk("rst_fl_literal", 256'(rrat_free_list[63:0]), 256'(64'hFFFFFFFF_00000000));
        chk("rst_fv", 256'(free_vector_from_rrat), 256'(0));
        chk("rst_nuke", 256'(nuke), 256'(0));
        @(negedge clock); reset = 1'b1;
        @(posedge clock); #1;
        chk_en = 1'b1;

        clear_in(); slot(0, 5, 40, 0); step();
        chk("a5_entry", 256'(rrat_entries[5]), 256'(40));
        chk("a5_fv", 256'(free_vector_from_rrat), 256'(64'h20));
        chk("a5_fl40", 256'(rrat_free_list[40]), 256'(0));
        chk("a5_fl5", 256'(rrat_free_list[5]), 256'(1));

        clear_in(); slot(0, 7, 41, 0); slot(1, 7, 42, 0); step();
        chk("dup_entry", 256'(rrat_entries[7]), 256'(42));
        chk("dup_fv", 256'(free_vector_from_rrat), 256'((64'h1 << 7) | (64'h1 << 41)));
        chk("dup_fl41", 256'(rrat_free_list[41]), 256'(1));
        chk("dup_fl42", 256'(rrat_free_list[42]), 256'(0));

        clear_in(); slot(0, 3, 50, 1); slot(1, 4, 51, 0); step();
        chk("mp_nuke", 256'(nuke), 256'(1));
        chk("mp_entry3", 256'(rrat_entries[3]), 256'(50));
        chk("mp_entry4", 256'(rrat_entries[4]), 256'(4));
        chk("mp_fl51", 256'(rrat_free_list[51]), 256'(1));
        clear_in(); slot(0, 9, 55, 1); step();
        chk("nk_ignored", 256'(rrat_entries[9]), 256'(9));
        chk("nk_off", 256'(nuke), 256'(0));
        chk("nk_fv", 256'(free_vector_from_rrat), 256'(0));

        clear_in(); slot(0, 0, 60, 0); step();
        chk("a0_fv", 256'(free_vector_from_rrat), 256'(0));
        chk("a0_fl60", 256'(rrat_free_list[60]), 256'(1));

        clear_in(); slot(1, 10, 45, 0); step();
        chk("gap_entry", 256'(rrat_entries[10]), 256'(45));
        clear_in(); step();
        chk("idle_fv", 256'(free_vector_from_rrat), 256'(0));

        for (int cyc = 0; cyc < 400; cyc++) begin
            clear_in();
            pool = model_free();
            for (int k = 0; k < NS; k++) begin
                if ($urandom_range(3) != 0) begin
                    do p = int'($urandom_range(PN - 1)); while (!pool[p]);
                    pool[p] = 1'b0;
                    slot(k, int'($urandom_range(RS - 1)) % (($urandom_range(7) == 0) ? 1 : RS),
                         p, $urandom_range(9) == 0);
                end
            end
            step();
        end

        clear_in(); slot(0, 12, 0, 1);
        pool = model_free();
        for (int q = PN - 1; q >= 0; q--) if (pool[q]) retire_phys_reg[0] = PB'(q);
        step();
        chk("pre_rst_nuke", 256'(nuke), 256'(1));
        chk_en = 1'b0;
        #2 reset = 1'b0;
        #1;
        model_reset();
        chk("async_nuke", 256'(nuke), 256'(0));
        chk("async_entries", 256'(rrat_entries), 256'(model_flat()));
        chk("async_e12", 256'(rrat_entries[12]), 256'(12));
        chk("async_fl", 256'(rrat_free_list), 256'(rst_fl));
        @(negedge clock); reset = 1'b1; clear_in();
        @(posedge clock); #1;
        chk_en = 1'b1;
        clear_in(); slot(0, 6, 33, 0); step();
        chk("post_rst_e6", 256'(rrat_entries[6]), 256'(33));
        step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/rrat_commit.md
RRAT_COMMIT -- requirements
Module: rrat_commit

Interface
REQ-001 The module SHALL be parameterized by the global macros below, as fixed by the build, one per line:
- `N`, default 3: retire width (slots per cycle).
- `RAT_SIZE`, default 32: architectural registers.
- `PRF_NUM_ENTRIES`, default 64: physical registers.
- `PRF_NUM_INDEX_BITS`, default 6: physical index width.
- `REG_INDEX_BITS`, default 5: architectural index width.

REQ-002 The module SHALL have the following ports, one per line:
- clock  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- retire_valid  in  [`N]  slot k retires this cycle; slot 0 is oldest.
- retire_arch_reg  in  [`N][REG_INDEX_BITS]  architectural destination of slot k; 0 means no destination.
- retire_phys_reg  in  [`N][PRF_NUM_INDEX_BITS]  physical destination of slot k.
- retire_mispredict  in  [`N]  slot k is a mispredicted branch.
- rrat_entries  out  [RAT_SIZE][PRF_NUM_INDEX_BITS]  committed arch-to-phys map.
- rrat_free_list  out  [PRF_NUM_ENTRIES]  1 = physical register not committed-live.
- free_vector_from_rrat  out  [PRF_NUM_ENTRIES]  one-hot-per-bit command to free physical registers.
- nuke  out  1  pipeline flush request.

Function
REQ-003 The module SHALL process valid slots in order 0..N-1 within a cycle; invalid slots are skipped, and contiguity of valid slots is not required.
REQ-004 For a processed slot with retire_arch_reg = a ≠ 0, the module SHALL:
- set the next rrat_entries[a] to retire_phys_reg;
- clear that phys bit in rrat_free_list;
- set the bit of the previous mapping of a in both rrat_free_list and free_vector_from_rrat.
REQ-005 A slot with retire_arch_reg = 0 SHALL change no table, free-list or free-vector bit.
REQ-006 When two or more slots in one cycle target the same arch register, the "previous mapping" for a younger slot SHALL be the older slot's retire_phys_reg. The older slot's phys is therefore freed in that cycle, and only the youngest survives in rrat_entries.
REQ-007 If retire_mispredict[k] is set on a valid slot k, slot k SHALL be processed. Slots k+1..N-1 SHALL be ignored that cycle. Only the lowest such k counts.
REQ-008 nuke SHALL be a registered output, high for exactly one cycle, in the cycle after a mispredicting slot retires. In that cycle rrat_entries and rrat_free_list already include the mispredicting slot's update.
REQ-009 While nuke is high, all retire inputs SHALL be ignored: no state update and no further nuke.
REQ-010 free_vector_from_rrat SHALL be registered, with a latency of 1 cycle from retirement. It SHALL be all-zero in any cycle following a cycle with no frees.
REQ-011 rrat_entries and rrat_free_list SHALL be driven directly from state registers, with no combinational path from the retire inputs.
REQ-012 For any physical register P, P's bit in rrat_free_list SHALL be 0 if and only if P appears in rrat_entries, in every cycle.

Reset
REQ-013 While reset = 0, asynchronously:
- rrat_entries[i] SHALL equal i for i = 0..RAT_SIZE-1;
- rrat_free_list bits 0..RAT_SIZE-1 SHALL be 0 and the remaining bits 1;
- free_vector_from_rrat SHALL be 0;
- nuke SHALL be 0.
REQ-014 Reset asserted mid-operation, including in the cycle a nuke is pending, SHALL discard all updates and the pending nuke.

Configuration
REQ-015 The macro RRAT_RETIRE_COUNT_EN SHALL select an optional retired-instruction counter:
- Defined: output retired_count, 64 bits, SHALL increment by the number of processed slots per cycle. It excludes ignored slots and cycles with nuke high, wraps modulo 2^64, and resets to 0.
- Undefined: the port and the counter SHALL be absent, with no other behavioural change.

Verification (N=2)
REQ-016 Reset release -> rrat_entries[5] = 5; rrat_free_list = 0xFFFFFFFF_00000000; nuke = 0; free_vector_from_rrat = 0.
REQ-017 Slot0 retires a=5, p=40 -> next cycle: rrat_entries[5] = 40; free_vector_from_rrat = bit 5 only; free_list bit 40 = 0 and bit 5 = 1.
REQ-018 In one cycle, slot0 retires a=7, p=41 and slot1 retires a=7, p=42 -> rrat_entries[7] = 42; free_vector bits 7 and 41 set; free_list bit 41 = 1 and bit 42 = 0.
REQ-019 Slot0 retires a=3, p=50 with mispredict and slot1 retires a=4, p=51 -> next cycle: nuke = 1, rrat_entries[3] = 50, rrat_entries[4] unchanged, bit 51 still free. Retire inputs presented during the nuke cycle are ignored, and nuke = 0 the cycle after.
REQ-020 Slot0 retires a=0, p=60 -> no change anywhere; free_vector_from_rrat = 0.
REQ-021 reset driven low asynchronously mid-cycle, one cycle after a mispredict retire -> nuke falls immediately, and the table returns to the identity map.
